// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   pipe_ctrl_state_e : sequencer state (RUN, DWAIT, FAULT)
//   stage_ctrl_t      : enable/flush pair for a flow register that can take a bubble
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    FAULT = 2'b10
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t StageRun    = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t StageHold   = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t StageBubble = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   id_rs1, id_rs2           ID source register indices
//   id_uses_rs1, id_uses_rs2 ID instruction actually reads the source
//   ex_rd                    EX destination register
//   ex_mem_read              EX instruction is a load
//   lu                       ID must wait one cycle for the load result
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  lu
);

  // x0 is hardwired zero, so a load to it never creates a dependency.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_*, ex_rd, ex_mem_read   operands for load-use detection
//   ex_redirect                EX resolved a taken branch/jump
//   imem_ready                 fetch data valid this cycle
//   dmem_req, dmem_ready       MEM-stage access and its completion
//   pc_en, *_en, *_flush       stage controls, combinational from state + inputs
//   fault                      sticky data-memory timeout
//   state_o                    current sequencer state
// Optional: define PIPE_PERF_CNT_EN to add saturating perf counters
//   perf_stall_cyc, perf_flush_cnt, perf_dwait_cyc (CNT_W bits each).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  fault,
  output logic [1:0]            state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cyc,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_dwait_cyc
`endif
);

  localparam int unsigned WaitW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitMax   = {WaitW{1'b1}};

  pipe_ctrl_state_e state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  logic lu;
  logic active;
  logic freeze;
  logic run_eval;

  logic        pc_en_c;
  stage_ctrl_t if_id_c;
  stage_ctrl_t id_ex_c;
  logic        ex_mem_en_c;
  logic        mem_wb_en_c;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  assign active   = (state_q == RUN) || (state_q == DWAIT);
  // Once in DWAIT the access is already outstanding, so dmem_req no longer matters.
  assign freeze   = active && !dmem_ready && (dmem_req || (state_q == DWAIT));
  // On the DWAIT release cycle the normal RUN priorities apply, which lets a
  // redirect held in the frozen EX stage take effect immediately.
  assign run_eval = active && !freeze;

  always_comb begin
    pc_en_c     = 1'b0;
    if_id_c     = StageHold;
    id_ex_c     = StageHold;
    ex_mem_en_c = 1'b0;
    mem_wb_en_c = 1'b0;

    if (run_eval) begin
      pc_en_c     = 1'b1;
      if_id_c     = StageRun;
      id_ex_c     = StageRun;
      ex_mem_en_c = 1'b1;
      mem_wb_en_c = 1'b1;
      if (ex_redirect) begin
        if_id_c = StageBubble;
        id_ex_c = StageBubble;
      end else if (lu) begin
        pc_en_c = 1'b0;
        if_id_c = StageHold;
        id_ex_c = StageBubble;
      end else if (!imem_ready) begin
        pc_en_c = 1'b0;
        if_id_c = StageBubble;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN, DWAIT: begin
        if (freeze) begin
          if (state_q == RUN) begin
            state_d    = DWAIT;
            wait_cnt_d = WaitW'(1);
          end else if (TimeoutEn && (wait_cnt_q == WaitLimit)) begin
            state_d = FAULT;
          end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Gate with rst_n so controls drop immediately on reset, without a clock edge.
  assign pc_en       = rst_n & pc_en_c;
  assign if_id_en    = rst_n & if_id_c.en;
  assign if_id_flush = rst_n & if_id_c.flush;
  assign id_ex_en    = rst_n & id_ex_c.en;
  assign id_ex_flush = rst_n & id_ex_c.flush;
  assign ex_mem_en   = rst_n & ex_mem_en_c;
  assign mem_wb_en   = rst_n & mem_wb_en_c;
  assign fault       = (state_q == FAULT);
  assign state_o     = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_act;
  logic redirect_act;

  assign redirect_act = run_eval && ex_redirect;
  assign stall_act    = run_eval && !ex_redirect && (lu || !imem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_dwait_cyc <= '0;
    end else begin
      if (stall_act && (perf_stall_cyc != {CNT_W{1'b1}})) begin
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
      end
      if (redirect_act && (perf_flush_cnt != {CNT_W{1'b1}})) begin
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
      if (freeze && (perf_dwait_cyc != {CNT_W{1'b1}})) begin
        perf_dwait_cyc <= perf_dwait_cyc + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4).
// Output vector bit order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//                           ex_mem_en, mem_wb_en, fault, state_o[1:0]}
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 32;
`endif

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       imem;
    logic       dreq;
    logic       drdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_req, dmem_ready;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, fault;
  logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] perf_stall_cyc, perf_flush_cnt, perf_dwait_cyc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_mode = 0;  // 0 running, 1 waiting on data memory, 2 faulted
  int m_cnt = 0;   // frozen cycles counted since the wait began

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .fault       (fault),
    .state_o     (state_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_dwait_cyc (perf_dwait_cyc)
`endif
  );

  function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                             input int rd, input bit ld, input bit redir, input bit imem,
                             input bit dreq, input bit drdy);
    in_t i;
    i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2; i.rd = 5'(rd);
    i.ld = ld; i.redir = redir; i.imem = imem; i.dreq = dreq; i.drdy = drdy;
    return i;
  endfunction

  function automatic logic [9:0] dut_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
            fault, state_o};
  endfunction

  // Reference: stage controls for the current model state and these inputs.
  function automatic logic [9:0] model_eval(input in_t i);
    logic hazard;
    logic [1:0] st;
    hazard = i.ld && (i.rd != 0) && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    st = 2'(m_mode);
    if (!rst_n) return 10'b0;
    if (m_mode == 2) return 10'b0000000110;
    if (!i.drdy && (i.dreq || m_mode == 1)) return {8'b0, st};
    if (i.redir) return {7'b1111111, 1'b0, st};
    if (hazard) return {7'b0001111, 1'b0, st};
    if (!i.imem) return {7'b0111011, 1'b0, st};
    return {7'b1101011, 1'b0, st};
  endfunction

  task automatic model_next(input in_t i);
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0;
    end else if (m_mode != 2) begin
      if (!i.drdy && (i.dreq || m_mode == 1)) begin
        if (m_mode == 0) begin
          m_mode = 1; m_cnt = 1;
        end else if (m_cnt == TO) begin
          m_mode = 2;
        end else begin
          m_cnt++;
        end
      end else begin
        m_mode = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic drive(input in_t i);
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
    ex_rd = i.rd; ex_mem_read = i.ld; ex_redirect = i.redir; imem_ready = i.imem;
    dmem_req = i.dreq; dmem_ready = i.drdy;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = dut_vec();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, compare at the falling edge, then advance.
  task automatic step(input in_t i, input logic [9:0] exp, input string name);
    drive(i);
    @(negedge clk);
    check(name, exp);
    model_next(i);
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input in_t i, input string name);
    drive(i);
    @(negedge clk);
    check(name, model_eval(i));
    model_next(i);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    check("reset_held", 10'b0000000000);
    m_mode = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];
  in_t  idle, frz, rel, rnd;
  int   fault_hold;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    frz  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    rel  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

    tbl.push_back('{"idle",         idle,                               10'b1101011000});
    tbl.push_back('{"lu_rs1",       mk(5, 0, 1, 0, 5, 1, 0, 1, 0, 0),   10'b0001111000});
    tbl.push_back('{"lu_rd0",       mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 0),   10'b1101011000});
    tbl.push_back('{"lu_rs2",       mk(1, 7, 0, 1, 7, 1, 0, 1, 0, 0),   10'b0001111000});
    tbl.push_back('{"rs1_unused",   mk(5, 0, 0, 0, 5, 1, 0, 1, 0, 0),   10'b1101011000});
    tbl.push_back('{"no_load",      mk(5, 0, 1, 0, 5, 0, 0, 1, 0, 0),   10'b1101011000});
    tbl.push_back('{"redir_lu_imem", mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0),  10'b1111111000});
    tbl.push_back('{"imem_wait",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   10'b0111011000});
    tbl.push_back('{"lu_over_imem", mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 0),   10'b0001111000});
    tbl.push_back('{"dmem_done",    mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1),   10'b1101011000});

    drive(idle);
    repeat (2) @(posedge clk);
    do_reset();

`ifdef PIPE_PERF_CNT_EN
    for (int k = 0; k < 5; k++) step(tbl[1].in, 10'b0001111000, "perf_lu");
    n_checks++;
    if (perf_stall_cyc !== 2'd3) begin
      n_errors++;
      $display("FAIL perf_stall_sat: got %0d expected 3", perf_stall_cyc);
    end
`endif

    foreach (tbl[k]) step(tbl[k].in, tbl[k].exp, tbl[k].name);

    // Data-memory wait: three frozen cycles, then release.
    step(frz, 10'b0000000000, "dwait_c1");
    step(frz, 10'b0000000001, "dwait_c2");
    step(frz, 10'b0000000001, "dwait_c3");
    step(rel, 10'b1101011001, "dwait_release");
    step(idle, 10'b1101011000, "dwait_back_run");

    // Redirect held in a frozen EX is applied on the release cycle.
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0), 10'b0000000000, "redir_frz1");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0), 10'b0000000001, "redir_frz2");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1), 10'b1111111001, "redir_release");
    step(idle, 10'b1101011000, "redir_back_run");

    // Timeout: FAULT after the fifth frozen cycle, then sticky regardless of inputs.
    step(frz, 10'b0000000000, "to_c1");
    for (int k = 0; k < 4; k++) step(frz, 10'b0000000001, "to_wait");
    for (int k = 0; k < 100; k++) begin
      rnd = in_t'($urandom);
      step(rnd, 10'b0000000110, "fault_sticky");
    end
    do_reset();
    step(idle, 10'b1101011000, "after_fault_reset");

    // Asynchronous reset mid-wait, between clock edges.
    step(frz, 10'b0000000000, "async_c1");
    step(frz, 10'b0000000001, "async_c2");
    drive(rel);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 10'b0000000000);
    m_mode = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(idle, 10'b1101011000, "async_after_release");
    // A fresh wait must again take five frozen cycles to fault.
    step(frz, 10'b0000000000, "async_to_c1");
    for (int k = 0; k < 4; k++) step(frz, 10'b0000000001, "async_to_wait");
    step(idle, 10'b0000000110, "async_to_fault");
    do_reset();

    // Random traffic against the reference model.
    fault_hold = 0;
    for (int k = 0; k < 2000; k++) begin
      rnd = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
               $urandom_range(0, 9) < 6);
      mstep(rnd, "random");
      if (m_mode == 2) fault_hold++;
      if (fault_hold >= 3) begin
        do_reset();
        fault_hold = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
